// File: rtl/riscv_core_dcache_nway_controller.sv
// N-way set-associative, write-through, write-allocate L1 D-cache tag/control engine.
// Optional hit/miss counters are enabled with the DCACHE_PERF_CNT_EN macro.
module riscv_core_dcache_nway_controller #(
    parameter int unsigned ADDR_WIDTH      = 64,
    parameter int unsigned CORE_DATA_WIDTH = 64,
    parameter int unsigned LINE_BYTES      = 32,
    parameter int unsigned INDEX_WIDTH     = 7,
    parameter int unsigned NUM_WAYS        = 2
) (
    input  logic                                           i_clk,
    input  logic                                           i_rst_n,
    input  logic [CORE_DATA_WIDTH-1:0]                     i_data_from_core,
    input  logic [ADDR_WIDTH-1:0]                          i_addr_from_core,
    input  logic                                           i_read,
    input  logic                                           i_write,
    input  logic [1:0]                                     i_size,
    input  logic                                           i_flush,
    output logic                                           o_stall,
    output logic                                           o_load_fault,
    output logic                                           o_store_fault,
    output logic                                           o_rd_en,
    output logic                                           o_wr_en,
    output logic                                           o_block_replace,
    output logic [((NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1)-1:0] o_way_sel,
    output logic                                           o_mem_read_req,
    output logic [ADDR_WIDTH-1:0]                          o_mem_read_address,
    input  logic                                           i_mem_read_done,
    output logic                                           o_mem_write_valid,
    output logic [CORE_DATA_WIDTH-1:0]                     o_mem_write_data,
    output logic [ADDR_WIDTH-1:0]                          o_mem_write_address,
    output logic [7:0]                                     o_mem_write_strobe,
    input  logic                                           i_mem_write_done,
    output logic                                           o_flush_busy
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]                                    o_hit_count,
    output logic [31:0]                                    o_miss_count
`endif
);

    localparam int unsigned OFFSET_WIDTH = $clog2(LINE_BYTES);
    localparam int unsigned NUM_SETS     = 2 ** INDEX_WIDTH;
    localparam int unsigned WAY_BITS     = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int unsigned TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;

    typedef enum logic [2:0] {StIdle, StRefill, StReplace, StWthru, StFlush} state_e;

    state_e                  state_q, state_d;
    logic [WAY_BITS-1:0]     victim_q, victim_d;
    logic [INDEX_WIDTH-1:0]  flush_cnt_q;
    logic [NUM_WAYS-1:0]     valid_q [NUM_SETS];
    logic [TAG_WIDTH-1:0]    tag_q [NUM_WAYS][NUM_SETS];

    logic [TAG_WIDTH-1:0]    req_tag;
    logic [INDEX_WIDTH-1:0]  req_index;
    logic [NUM_WAYS-1:0]     set_valid;
    logic                    hit;
    logic [WAY_BITS-1:0]     hit_way;
    logic [WAY_BITS-1:0]     ptr_cur;
    logic [WAY_BITS-1:0]     victim_way;
    logic                    fault;
    logic [3:0]              size_bytes;
    logic [3:0]              end_off;
    logic [7:0]              size_mask;
    logic [15:0]             strobe_wide;
    logic                    miss_start;
    logic                    flush_done;

    assign req_tag   = i_addr_from_core[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign req_index = i_addr_from_core[OFFSET_WIDTH +: INDEX_WIDTH];
    assign set_valid = valid_q[req_index];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (set_valid[w] && (tag_q[w][req_index] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
        end
    end

    // Lowest-numbered invalid way wins; a full set falls back to the round-robin pointer.
    always_comb begin
        victim_way = ptr_cur;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!set_valid[w]) begin
                victim_way = WAY_BITS'(w);
            end
        end
    end

    assign size_bytes = 4'd1 << i_size;
    assign end_off    = {1'b0, i_addr_from_core[2:0]} + size_bytes;
    assign fault      = end_off > 4'd8;

    always_comb begin
        size_mask = 8'h00;
        unique case (i_size)
            2'd0: size_mask = 8'h01;
            2'd1: size_mask = 8'h03;
            2'd2: size_mask = 8'h0F;
            2'd3: size_mask = 8'hFF;
            default: size_mask = 8'h00;
        endcase
    end

    assign strobe_wide         = {8'h00, size_mask} << i_addr_from_core[2:0];
    assign o_mem_write_strobe  = strobe_wide[7:0];
    assign o_mem_write_data    = i_data_from_core;
    assign o_mem_write_address = i_addr_from_core;
    assign o_mem_read_address  = {i_addr_from_core[ADDR_WIDTH-1:OFFSET_WIDTH],
                                  {OFFSET_WIDTH{1'b0}}};

    assign o_load_fault  = i_rst_n & fault & i_read;
    assign o_store_fault = i_rst_n & fault & i_write;
    assign o_way_sel     = !i_rst_n ? '0 :
                           ((state_q == StRefill) || (state_q == StReplace)) ? victim_q : hit_way;

    always_comb begin
        state_d           = state_q;
        victim_d          = victim_q;
        o_stall           = 1'b0;
        o_rd_en           = 1'b0;
        o_wr_en           = 1'b0;
        o_block_replace   = 1'b0;
        o_mem_read_req    = 1'b0;
        o_mem_write_valid = 1'b0;
        o_flush_busy      = 1'b0;
        miss_start        = 1'b0;
        if (i_rst_n) begin
            unique case (state_q)
                StIdle: begin
                    if (i_flush) begin
                        o_stall = 1'b1;
                        state_d = StFlush;
                    end else if ((i_read || i_write) && !fault) begin
                        if (hit && i_read) begin
                            o_rd_en = 1'b1;
                        end else if (hit) begin
                            o_wr_en           = 1'b1;
                            o_mem_write_valid = 1'b1;
                            o_stall           = 1'b1;
                            state_d           = StWthru;
                        end else begin
                            o_stall        = 1'b1;
                            o_mem_read_req = 1'b1;
                            victim_d       = victim_way;
                            miss_start     = 1'b1;
                            state_d        = StRefill;
                        end
                    end
                end
                StRefill: begin
                    o_stall = 1'b1;
                    if (i_mem_read_done) begin
                        state_d = StReplace;
                    end else begin
                        o_mem_read_req = 1'b1;
                    end
                end
                StReplace: begin
                    o_stall         = 1'b1;
                    o_wr_en         = 1'b1;
                    o_block_replace = 1'b1;
                    state_d         = StIdle;
                end
                StWthru: begin
                    if (i_mem_write_done) begin
                        state_d = StIdle;
                    end else begin
                        o_stall           = 1'b1;
                        o_mem_write_valid = 1'b1;
                    end
                end
                StFlush: begin
                    o_stall      = 1'b1;
                    o_flush_busy = 1'b1;
                    if (flush_cnt_q == INDEX_WIDTH'(NUM_SETS - 1)) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign flush_done = (state_q == StFlush) && (state_d == StIdle);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            victim_q    <= '0;
            flush_cnt_q <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
            end
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            if (state_q == StReplace) begin
                valid_q[req_index][victim_q] <= 1'b1;
            end
            if (state_q == StFlush) begin
                valid_q[flush_cnt_q] <= '0;
                flush_cnt_q          <= flush_cnt_q + 1'b1;
            end
        end
    end

    // Tags need no reset: they are only trusted behind a valid bit.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && (state_q == StReplace)) begin
            tag_q[victim_q][req_index] <= req_tag;
        end
    end

    if (NUM_WAYS > 1) begin : g_ptr
        logic [WAY_BITS-1:0] ptr_q [NUM_SETS];

        always_ff @(posedge i_clk) begin
            if (!i_rst_n || flush_done) begin
                for (int s = 0; s < NUM_SETS; s++) begin
                    ptr_q[s] <= '0;
                end
            end else if ((state_q == StReplace) && (&set_valid)) begin
                ptr_q[req_index] <= ptr_q[req_index] + 1'b1;
            end
        end

        assign ptr_cur = ptr_q[req_index];
    end else begin : g_no_ptr
        assign ptr_cur = '0;
    end

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || flush_done) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if ((state_q == StIdle) && (o_rd_en || o_wr_en) && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_start && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign o_hit_count  = hit_cnt_q;
    assign o_miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_riscv_core_dcache_nway_controller.sv
// Directed self-checking bench for the N-way D-cache controller (default 2-way, 32B lines).
module tb_riscv_core_dcache_nway_controller;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [63:0] i_data_from_core;
    logic [63:0] i_addr_from_core;
    logic        i_read;
    logic        i_write;
    logic [1:0]  i_size;
    logic        i_flush;
    logic        o_stall;
    logic        o_load_fault;
    logic        o_store_fault;
    logic        o_rd_en;
    logic        o_wr_en;
    logic        o_block_replace;
    logic [0:0]  o_way_sel;
    logic        o_mem_read_req;
    logic [63:0] o_mem_read_address;
    logic        i_mem_read_done;
    logic        o_mem_write_valid;
    logic [63:0] o_mem_write_data;
    logic [63:0] o_mem_write_address;
    logic [7:0]  o_mem_write_strobe;
    logic        i_mem_write_done;
    logic        o_flush_busy;

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    riscv_core_dcache_nway_controller dut (
        .i_clk               (i_clk),
        .i_rst_n             (i_rst_n),
        .i_data_from_core    (i_data_from_core),
        .i_addr_from_core    (i_addr_from_core),
        .i_read              (i_read),
        .i_write             (i_write),
        .i_size              (i_size),
        .i_flush             (i_flush),
        .o_stall             (o_stall),
        .o_load_fault        (o_load_fault),
        .o_store_fault       (o_store_fault),
        .o_rd_en             (o_rd_en),
        .o_wr_en             (o_wr_en),
        .o_block_replace     (o_block_replace),
        .o_way_sel           (o_way_sel),
        .o_mem_read_req      (o_mem_read_req),
        .o_mem_read_address  (o_mem_read_address),
        .i_mem_read_done     (i_mem_read_done),
        .o_mem_write_valid   (o_mem_write_valid),
        .o_mem_write_data    (o_mem_write_data),
        .o_mem_write_address (o_mem_write_address),
        .o_mem_write_strobe  (o_mem_write_strobe),
        .i_mem_write_done    (i_mem_write_done),
        .o_flush_busy        (o_flush_busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [63:0] a,
                         input logic [1:0] sz, input logic [63:0] d);
        i_read           = rd;
        i_write          = wr;
        i_addr_from_core = a;
        i_size           = sz;
        i_data_from_core = d;
        #1;
    endtask

    // Entered in the IDLE cycle of a missing access; leaves in the replay cycle.
    task automatic refill(input string tag, input logic [63:0] a, input logic [63:0] exp_way);
        check_eq({tag, "_miss_stall"}, o_stall, 1);
        check_eq({tag, "_miss_req"}, o_mem_read_req, 1);
        check_eq({tag, "_miss_rd_en"}, o_rd_en, 0);
        check_eq({tag, "_raddr"}, o_mem_read_address, {a[63:5], 5'b0});
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            if (i == 0) check_eq({tag, "_refill_req"}, o_mem_read_req, 1);
        end
        tick();
        i_mem_read_done = 1'b1;
        #1;
        check_eq({tag, "_done_req"}, o_mem_read_req, 0);
        check_eq({tag, "_done_stall"}, o_stall, 1);
        tick();
        i_mem_read_done = 1'b0;
        #1;
        check_eq({tag, "_repl_wr"}, o_wr_en, 1);
        check_eq({tag, "_repl_blk"}, o_block_replace, 1);
        check_eq({tag, "_repl_way"}, o_way_sel, exp_way);
        tick();
        #1;
    endtask

    task automatic read_hit(input string tag, input logic [63:0] exp_way);
        check_eq({tag, "_rd_en"}, o_rd_en, 1);
        check_eq({tag, "_way"}, o_way_sel, exp_way);
        check_eq({tag, "_stall"}, o_stall, 0);
    endtask

    initial begin
        int n;
        i_rst_n          = 1'b0;
        i_flush          = 1'b0;
        i_mem_read_done  = 1'b0;
        i_mem_write_done = 1'b0;
        drive(1, 0, 64'h1000, 2'd3, 64'h0);
        tick();
        tick();
        #1;
        check_eq("rst_stall", o_stall, 0);
        check_eq("rst_req", o_mem_read_req, 0);
        check_eq("rst_rd_en", o_rd_en, 0);
        check_eq("rst_strobe", o_mem_write_strobe, 8'hFF);
        check_eq("rst_waddr", o_mem_write_address, 64'h1000);

        // Cold miss, then replay hit in way 0.
        i_rst_n = 1'b1;
        #1;
        refill("cold", 64'h1000, 0);
        read_hit("cold_hit", 0);

        tick();
        drive(1, 0, 64'h2000, 2'd3, 64'h0);
        refill("fill1", 64'h2000, 1);
        read_hit("fill1_hit", 1);

        // Full set: pointer 0 evicts 0x1000, pointer moves to 1.
        tick();
        drive(1, 0, 64'h3000, 2'd3, 64'h0);
        refill("evict", 64'h3000, 0);
        read_hit("evict_hit", 0);

        tick();
        drive(1, 0, 64'h2000, 2'd3, 64'h0);
        read_hit("hit2000", 1);

        tick();
        drive(1, 0, 64'h1000, 2'd3, 64'h0);
        refill("rr", 64'h1000, 1);
        read_hit("rr_hit", 1);

        // Store D hit on way 1, write-through done three cycles later.
        tick();
        drive(0, 1, 64'h1008, 2'd3, 64'hDEAD_BEEF_0123_4567);
        check_eq("sd_wr_en", o_wr_en, 1);
        check_eq("sd_strobe", o_mem_write_strobe, 8'hFF);
        check_eq("sd_wvalid", o_mem_write_valid, 1);
        check_eq("sd_stall", o_stall, 1);
        check_eq("sd_way", o_way_sel, 1);
        check_eq("sd_wdata", o_mem_write_data, 64'hDEAD_BEEF_0123_4567);
        check_eq("sd_waddr", o_mem_write_address, 64'h1008);
        tick();
        #1;
        check_eq("wt1_stall", o_stall, 1);
        check_eq("wt1_wvalid", o_mem_write_valid, 1);
        check_eq("wt1_wr_en", o_wr_en, 0);
        tick();
        #1;
        check_eq("wt2_stall", o_stall, 1);
        tick();
        i_mem_write_done = 1'b1;
        #1;
        check_eq("wt_done_stall", o_stall, 0);
        check_eq("wt_done_wvalid", o_mem_write_valid, 0);
        tick();
        i_mem_write_done = 1'b0;
        drive(0, 0, 64'h1000, 2'd3, 64'h0);
        check_eq("wt_idle_stall", o_stall, 0);

        // Store H at byte 6.
        drive(0, 1, 64'h100E, 2'd1, 64'h0);
        check_eq("sh_strobe", o_mem_write_strobe, 8'hC0);
        check_eq("sh_wr_en", o_wr_en, 1);
        check_eq("sh_fault", o_store_fault, 0);
        tick();
        i_mem_write_done = 1'b1;
        #1;
        check_eq("sh_done_stall", o_stall, 0);
        tick();
        i_mem_write_done = 1'b0;

        // Misaligned accesses.
        drive(0, 1, 64'h1005, 2'd2, 64'h0);
        check_eq("sw_fault", o_store_fault, 1);
        check_eq("sw_stall", o_stall, 0);
        check_eq("sw_wr_en", o_wr_en, 0);
        check_eq("sw_wvalid", o_mem_write_valid, 0);
        check_eq("sw_req", o_mem_read_req, 0);
        drive(1, 0, 64'h1007, 2'd1, 64'h0);
        check_eq("lh_fault", o_load_fault, 1);
        check_eq("lh_sfault", o_store_fault, 0);
        check_eq("lh_rd_en", o_rd_en, 0);
        check_eq("lh_stall", o_stall, 0);

        tick();
        drive(1, 0, 64'h1020, 2'd3, 64'h0);
        refill("set1", 64'h1020, 0);
        read_hit("set1_hit", 0);

        // Flush with three valid lines.
        tick();
        drive(0, 0, 64'h0, 2'd3, 64'h0);
        i_flush = 1'b1;
        #1;
        check_eq("flush_req_busy", o_flush_busy, 0);
        tick();
        i_flush = 1'b0;
        n = 0;
        #1;
        while (o_flush_busy && n < 300) begin
            n++;
            tick();
            #1;
        end
        check_eq("flush_len", n, 128);
        check_eq("flush_exit_stall", o_stall, 0);

        drive(1, 0, 64'h1000, 2'd3, 64'h0);
        refill("pf1000", 64'h1000, 0);
        tick();
        drive(1, 0, 64'h3000, 2'd3, 64'h0);
        refill("pf3000", 64'h3000, 1);
        tick();
        drive(1, 0, 64'h1020, 2'd3, 64'h0);
        refill("pf1020", 64'h1020, 0);

        // Reset in the middle of a refill.
        tick();
        drive(1, 0, 64'h5000, 2'd3, 64'h0);
        check_eq("r5_stall", o_stall, 1);
        check_eq("r5_req", o_mem_read_req, 1);
        tick();
        tick();
        i_rst_n = 1'b0;
        #1;
        check_eq("mid_rst_stall", o_stall, 0);
        check_eq("mid_rst_req", o_mem_read_req, 0);
        check_eq("mid_rst_way", o_way_sel, 0);
        tick();
        #1;
        check_eq("post_rst_stall", o_stall, 0);
        check_eq("post_rst_req", o_mem_read_req, 0);
        i_rst_n = 1'b1;
        #1;
        refill("rst5000", 64'h5000, 0);
        read_hit("rst5000_hit", 0);
        tick();
        drive(1, 0, 64'h1000, 2'd3, 64'h0);
        refill("rst1000", 64'h1000, 1);
        read_hit("rst1000_hit", 1);

        tick();
        drive(0, 0, 64'h0, 2'd3, 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
